e203_ifu_jalr_rdport_ctrl: RTL and testbench

Sequences JALR-with-rs1=xN target resolution for the IFU lite branch predictor: waits out pipeline dependencies, issues the regfile read, and holds the operand until the IFU consumes it. Shares the single BPU regfile read port with a debug-register read requester, with fixed priority to the BPU. Sits between the IFU mini-decoder/BPU and the regfile's BPU read port; it also emits a saturating stall counter for performance monitoring.

---
 rtl/e203_ifu_jalr_rdport_ctrl_pkg.sv | 20 ++
 rtl/e203_ifu_sat_cnt.sv | 21 ++
 rtl/e203_ifu_jalr_rdport_ctrl.sv | 103 ++++++++++
 tb/tb_e203_ifu_jalr_rdport_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/e203_ifu_jalr_rdport_ctrl_pkg.sv
// e203_ifu_jalr_rdport_ctrl_pkg: shared widths, FSM encoding and dependency helper
package e203_ifu_jalr_rdport_ctrl_pkg;

    localparam int E203_XLEN    = 32;
    localparam int E203_RFIDX_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RD   = 2'd2,
        S_HOLD = 2'd3
    } jalr_state_e;

    // rs1 may still be written by an outstanding EXU op or the instruction sitting in IR
    function automatic logic jalr_dep(input logic oitf_empty, input logic ir_empty,
                                      input logic ir_rs1en, input logic ir_valid_clr);
        return ~oitf_empty | (~ir_empty & ir_rs1en & ~ir_valid_clr);
    endfunction

endpackage

// File: rtl/e203_ifu_sat_cnt.sv
// e203_ifu_sat_cnt: width-parameterised saturating up-counter with clear
module e203_ifu_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/e203_ifu_jalr_rdport_ctrl.sv
// e203_ifu_jalr_rdport_ctrl: JALR rs1 operand sequencer sharing the BPU regfile port with debug reads
module e203_ifu_jalr_rdport_ctrl
    import e203_ifu_jalr_rdport_ctrl_pkg::*;
#(
    parameter int XLEN        = E203_XLEN,
    parameter int RFIDX_W     = E203_RFIDX_W,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   jalr_req,
    input  logic [RFIDX_W-1:0]     jalr_rs1idx,
    input  logic                   oitf_empty,
    input  logic                   ir_empty,
    input  logic                   ir_rs1en,
    input  logic                   ir_valid_clr,
    input  logic                   flush,
    input  logic                   jalr_ack,
    output logic                   bpu_wait,
    output logic                   jalr_op_vld,
    output logic [XLEN-1:0]        jalr_op,
    input  logic                   dbg_rd_req,
    input  logic [RFIDX_W-1:0]     dbg_rd_idx,
    output logic                   dbg_rd_gnt,
    output logic                   dbg_rd_rvld,
    output logic [XLEN-1:0]        dbg_rd_rdata,
    output logic                   rf_rd_ena,
    output logic [RFIDX_W-1:0]     rf_rd_idx,
    input  logic [XLEN-1:0]        rf_rd_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    jalr_state_e state;
    logic        dep;
    logic        bpu_rd;
    logic        idle_to_rd;

    assign dep        = jalr_dep(oitf_empty, ir_empty, ir_rs1en, ir_valid_clr);
    assign idle_to_rd = (state == S_IDLE) & jalr_req & ~dep;
    assign bpu_rd     = (state == S_RD) & jalr_req & ~flush;
    // debug yields in RD and in the IDLE cycle that heads straight into RD
    assign dbg_rd_gnt = dbg_rd_req & (state != S_RD) & ~idle_to_rd;
    assign rf_rd_ena  = bpu_rd | dbg_rd_gnt;
    assign rf_rd_idx  = bpu_rd ? jalr_rs1idx : dbg_rd_gnt ? dbg_rd_idx : '0;
    assign bpu_wait   = jalr_req & (state != S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            jalr_op_vld <= 1'b0;
            jalr_op     <= '0;
        end else if (flush) begin
            state       <= S_IDLE;
            jalr_op_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (jalr_req) state <= dep ? S_WAIT : S_RD;
                S_WAIT: begin
                    if (!jalr_req)
                        state <= S_IDLE;
                    else if (!dep)
                        state <= S_RD;
                end
                S_RD: begin
                    if (!jalr_req)
                        state <= S_IDLE;
                    else begin
                        state       <= S_HOLD;
                        jalr_op_vld <= 1'b1;
                        jalr_op     <= rf_rd_data;
                    end
                end
                S_HOLD: begin
                    if (jalr_ack) begin
                        state       <= S_IDLE;
                        jalr_op_vld <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rd_rvld  <= 1'b0;
            dbg_rd_rdata <= '0;
        end else begin
            dbg_rd_rvld <= dbg_rd_gnt;
            if (dbg_rd_gnt)
                dbg_rd_rdata <= rf_rd_data;
        end
    end

    e203_ifu_sat_cnt #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == S_WAIT),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_e203_ifu_jalr_rdport_ctrl.sv
// tb_e203_ifu_jalr_rdport_ctrl: directed vector table, reset/saturation sequences, randomized model check
module tb_e203_ifu_jalr_rdport_ctrl;

    localparam int SCW = 2;
    localparam int CMAX = (1 << SCW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           jalr_req, oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, flush, jalr_ack;
    logic [4:0]     jalr_rs1idx, dbg_rd_idx, rf_rd_idx;
    logic           dbg_rd_req, dbg_rd_gnt, dbg_rd_rvld, rf_rd_ena, bpu_wait, jalr_op_vld;
    logic [31:0]    jalr_op, dbg_rd_rdata, rf_rd_data;
    logic [SCW-1:0] stall_cnt;
    logic [31:0]    rf [32];

    assign rf_rd_data = rf[rf_rd_idx];

    e203_ifu_jalr_rdport_ctrl #(.XLEN(32), .RFIDX_W(5), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .jalr_req(jalr_req), .jalr_rs1idx(jalr_rs1idx),
        .oitf_empty(oitf_empty), .ir_empty(ir_empty), .ir_rs1en(ir_rs1en),
        .ir_valid_clr(ir_valid_clr), .flush(flush), .jalr_ack(jalr_ack),
        .bpu_wait(bpu_wait), .jalr_op_vld(jalr_op_vld), .jalr_op(jalr_op),
        .dbg_rd_req(dbg_rd_req), .dbg_rd_idx(dbg_rd_idx), .dbg_rd_gnt(dbg_rd_gnt),
        .dbg_rd_rvld(dbg_rd_rvld), .dbg_rd_rdata(dbg_rd_rdata), .rf_rd_ena(rf_rd_ena),
        .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ins = {req, oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, flush, ack, dbg_req}
    // ex  = {bpu_wait, jalr_op_vld, rf_rd_ena, dbg_rd_gnt, dbg_rd_rvld}
    typedef struct {
        logic [7:0]  ins;
        logic [4:0]  idx;
        logic [4:0]  didx;
        logic [4:0]  ex;
        logic [4:0]  eidx;
        logic [31:0] op;
        logic [31:0] rd;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] ins, logic [4:0] idx, logic [4:0] didx, logic [4:0] ex,
                                logic [4:0] eidx, logic [31:0] op, logic [31:0] rd, logic [1:0] cnt);
        vec_t v;
        v.ins = ins; v.idx = idx; v.didx = didx; v.ex = ex;
        v.eidx = eidx; v.op = op; v.rd = rd; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic [7:0] ins, input logic [4:0] idx, input logic [4:0] didx);
        {jalr_req, oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, flush, jalr_ack, dbg_rd_req} = ins;
        jalr_rs1idx = idx;
        dbg_rd_idx  = didx;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".bpu_wait"}, bpu_wait, 0);
        chk({tag, ".jalr_op_vld"}, jalr_op_vld, 0);
        chk({tag, ".jalr_op"}, jalr_op, 0);
        chk({tag, ".rf_rd_ena"}, rf_rd_ena, 0);
        chk({tag, ".dbg_rd_gnt"}, dbg_rd_gnt, 0);
        chk({tag, ".dbg_rd_rvld"}, dbg_rd_rvld, 0);
        chk({tag, ".dbg_rd_rdata"}, dbg_rd_rdata, 0);
        chk({tag, ".stall_cnt"}, stall_cnt, 0);
    endtask

    // reference model: which phase of the JALR sequence we are in, plus latched data
    logic        m_wait, m_read, m_ready, m_rvld;
    logic [31:0] m_op, m_rdata;
    int          m_cnt;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[5] = 32'h8000_0040;
        rf[3] = 32'h0000_1234;
        rf[7] = 32'hCAFE_0007;
        drive(8'b0, 5'd0, 5'd0);

        tbl.push_back(mk(8'b1110_0000, 5, 0, 5'b10000, 0, 0, 0, 0));
        tbl.push_back(mk(8'b1110_0000, 5, 0, 5'b10100, 5, 0, 0, 0));
        tbl.push_back(mk(8'b1110_0010, 5, 0, 5'b01000, 0, 32'h8000_0040, 0, 0));
        tbl.push_back(mk(8'b0110_0000, 5, 0, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(mk(8'b1010_0000, 5, 0, 5'b10000, 0, 0, 0, 0));
        tbl.push_back(mk(8'b1010_0000, 5, 0, 5'b10000, 0, 0, 0, 0));
        tbl.push_back(mk(8'b1010_0000, 5, 0, 5'b10000, 0, 0, 0, 1));
        tbl.push_back(mk(8'b1110_0000, 5, 0, 5'b10000, 0, 0, 0, 2));
        tbl.push_back(mk(8'b1110_0000, 5, 0, 5'b10100, 5, 0, 0, 3));
        tbl.push_back(mk(8'b1110_0010, 5, 0, 5'b01000, 0, 32'h8000_0040, 0, 3));
        tbl.push_back(mk(8'b1101_1000, 7, 0, 5'b10000, 0, 0, 0, 3));
        tbl.push_back(mk(8'b1101_1001, 7, 3, 5'b10100, 7, 0, 0, 3));
        tbl.push_back(mk(8'b1110_0001, 7, 3, 5'b01110, 3, 32'hCAFE_0007, 0, 3));
        tbl.push_back(mk(8'b1110_0100, 7, 3, 5'b01001, 0, 32'hCAFE_0007, 32'h1234, 3));
        tbl.push_back(mk(8'b1110_0000, 5, 0, 5'b10000, 0, 0, 0, 3));
        tbl.push_back(mk(8'b1110_0100, 5, 0, 5'b10000, 0, 0, 0, 3));
        tbl.push_back(mk(8'b1110_0001, 5, 3, 5'b10000, 0, 0, 0, 3));
        tbl.push_back(mk(8'b0110_0001, 5, 3, 5'b00000, 0, 0, 0, 3));
        tbl.push_back(mk(8'b0110_0001, 5, 3, 5'b00110, 3, 0, 0, 3));
        tbl.push_back(mk(8'b0110_0001, 5, 3, 5'b00111, 3, 0, 32'h1234, 3));
        tbl.push_back(mk(8'b0110_0000, 5, 0, 5'b00001, 0, 0, 32'h1234, 3));
        tbl.push_back(mk(8'b0110_0000, 5, 0, 5'b00000, 0, 0, 0, 3));

        #12;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[k]) begin
            drive(tbl[k].ins, tbl[k].idx, tbl[k].didx);
            @(negedge clk);
            chk($sformatf("vec%0d.bpu_wait", k), bpu_wait, tbl[k].ex[4]);
            chk($sformatf("vec%0d.jalr_op_vld", k), jalr_op_vld, tbl[k].ex[3]);
            chk($sformatf("vec%0d.rf_rd_ena", k), rf_rd_ena, tbl[k].ex[2]);
            chk($sformatf("vec%0d.dbg_rd_gnt", k), dbg_rd_gnt, tbl[k].ex[1]);
            chk($sformatf("vec%0d.dbg_rd_rvld", k), dbg_rd_rvld, tbl[k].ex[0]);
            chk($sformatf("vec%0d.stall_cnt", k), stall_cnt, tbl[k].cnt);
            if (tbl[k].ex[2]) chk($sformatf("vec%0d.rf_rd_idx", k), rf_rd_idx, tbl[k].eidx);
            if (tbl[k].ex[3]) chk($sformatf("vec%0d.jalr_op", k), jalr_op, tbl[k].op);
            if (tbl[k].ex[0]) chk($sformatf("vec%0d.dbg_rd_rdata", k), dbg_rd_rdata, tbl[k].rd);
            @(posedge clk); #1;
        end

        // async reset while waiting on a dependency
        drive(8'b1010_0000, 5, 0);
        repeat (3) @(posedge clk);
        #3;
        drive(8'b0110_0000, 5, 0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // saturation of the stall counter
        @(posedge clk); #1;
        drive(8'b1010_0000, 5, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("sat.after2", stall_cnt, 2);
        repeat (4) @(posedge clk);
        #1;
        chk("sat.after6", stall_cnt, CMAX);
        chk("sat.bpu_wait", bpu_wait, 1);

        // randomized run against the reference model
        drive(8'b0110_0000, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_wait = 0; m_read = 0; m_ready = 0; m_rvld = 0;
        m_op = 0; m_rdata = 0; m_cnt = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            logic dep, e_rd, e_gnt, e_idle;
            jalr_req     = ($urandom % 4) != 0;
            jalr_rs1idx  = 5'($urandom);
            oitf_empty   = ($urandom % 3) != 0;
            ir_empty     = $urandom % 2;
            ir_rs1en     = $urandom % 2;
            ir_valid_clr = $urandom % 2;
            flush        = ($urandom % 16) == 0;
            jalr_ack     = $urandom % 2;
            dbg_rd_req   = ($urandom % 3) == 0;
            dbg_rd_idx   = 5'($urandom);
            dep    = !oitf_empty || (!ir_empty && ir_rs1en && !ir_valid_clr);
            e_idle = !m_wait && !m_read && !m_ready;
            e_rd   = m_read && jalr_req && !flush;
            e_gnt  = dbg_rd_req && !m_read && !(e_idle && jalr_req && !dep);
            @(negedge clk);
            chk("rnd.bpu_wait", bpu_wait, jalr_req && !m_ready);
            chk("rnd.jalr_op_vld", jalr_op_vld, m_ready);
            chk("rnd.jalr_op", jalr_op, m_op);
            chk("rnd.dbg_rd_gnt", dbg_rd_gnt, e_gnt);
            chk("rnd.rf_rd_ena", rf_rd_ena, e_rd || e_gnt);
            if (e_rd || e_gnt) chk("rnd.rf_rd_idx", rf_rd_idx, e_rd ? jalr_rs1idx : dbg_rd_idx);
            chk("rnd.dbg_rd_rvld", dbg_rd_rvld, m_rvld);
            chk("rnd.dbg_rd_rdata", dbg_rd_rdata, m_rdata);
            chk("rnd.stall_cnt", stall_cnt, m_cnt);
            @(posedge clk);
            if (m_wait && m_cnt < CMAX) m_cnt++;
            m_rvld = e_gnt;
            if (e_gnt) m_rdata = rf[dbg_rd_idx];
            if (flush) begin
                m_wait = 0; m_read = 0; m_ready = 0;
            end else if (m_ready) begin
                if (jalr_ack) m_ready = 0;
            end else if (m_read) begin
                m_read = 0;
                if (jalr_req) begin
                    m_ready = 1;
                    m_op = rf[jalr_rs1idx];
                end
            end else if (m_wait) begin
                if (!jalr_req) m_wait = 0;
                else if (!dep) begin
                    m_wait = 0;
                    m_read = 1;
                end
            end else if (jalr_req) begin
                m_wait = dep;
                m_read = !dep;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
